// File: rtl/cmos_axis_pkg.sv
// Shared types and constants for the CMOS RGB565 to AXI4-Stream bridge.
package cmos_axis_pkg;

   localparam int CNT_W   = 12;
   localparam int DATA_W  = 16;
   // FIFO entry layout: {tuser, tlast, tdata}
   localparam int ENTRY_W = DATA_W + 2;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      SYNC    = 2'd1,
      ACTIVE  = 2'd2,
      DROP    = 2'd3
   } state_t;

   // Saturating increment for the geometry counters.
   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + cnt_t'(1);
   endfunction

endpackage

// File: rtl/sync_fifo_v1.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// o_data whenever o_empty is low. A push while full is accepted only when a
// pop happens in the same cycle.
module sync_fifo_v1 #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   // Storage array; contents need no reset because o_empty qualifies them.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cmos_rgb565_axis_bridge.sv
// Re-frames the gated CMOS decoder pixel stream as AXI4-Stream video
// (tuser = start of frame, tlast = end of line), buffers it for downstream
// backpressure and measures frame geometry.
//
//  state   | meaning
//  WAIT_VS | after reset, discard everything until the first vsync rise
//  SYNC    | frame started, waiting for its first pixel (tagged tuser)
//  ACTIVE  | forwarding pixels through the hold register into the FIFO
//  DROP    | FIFO overflowed, discard the rest of the frame
module cmos_rgb565_axis_bridge
   import cmos_axis_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              cmos_pclk_i,
   input  logic              rst_n_i,
   input  logic              vs_i,
   input  logic              hs_i,
   input  logic [DATA_W-1:0] rgb565_i,
   input  logic              vid_clk_ce_i,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tuser,
   output logic              m_axis_tlast,
   output logic [CNT_W-1:0]  pix_cnt_o,
   output logic [CNT_W-1:0]  line_cnt_o,
   output logic              ovf_o,
   output logic              frame_err_o
);

   logic              r_vs_q;
   logic              r_hs_q;
   state_t            r_state;
   logic              r_hold_full;
   logic              r_hold_sof;
   logic [DATA_W-1:0] r_hold_data;
   cnt_t              r_pix_cnt;
   cnt_t              r_line_cnt;
   logic              r_line_open;
   logic              r_err_acc;
   cnt_t              r_pix_cnt_o;
   cnt_t              r_line_cnt_o;
   logic              r_ovf;
   logic              r_frame_err;

   logic               w_vs_rise;
   logic               w_hs_fall;
   logic               w_pix_vld;
   logic               w_accept;
   logic               w_push;
   logic [ENTRY_W-1:0] w_push_entry;
   logic               w_hold_load;
   logic               w_hold_clear;
   logic               w_trunc;
   logic               w_pop;
   logic               w_ovf;
   logic               w_fifo_push;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [ENTRY_W-1:0] w_head;
   logic               w_count_en;
   logic               w_line_end;
   logic               w_width_bad;
   cnt_t               w_line_next;
   logic               w_frame_bad;

   assign w_vs_rise = vs_i & ~r_vs_q;
   assign w_hs_fall = ~hs_i & r_hs_q;
   assign w_pix_vld = vid_clk_ce_i & hs_i;
   assign w_accept  = (r_state == SYNC) || (r_state == ACTIVE);

   // Input edge detection registers.
   always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_vs_q <= 1'b0;
         r_hs_q <= 1'b0;
      end else begin
         r_vs_q <= vs_i;
         r_hs_q <= hs_i;
      end
   end

   // Push decision: the held pixel leaves when its successor, the end of its
   // line, or a premature vsync arrives. Only one source can win per cycle.
   always_comb begin
      w_push       = 1'b0;
      w_push_entry = '0;
      w_hold_load  = 1'b0;
      w_hold_clear = 1'b0;
      w_trunc      = 1'b0;
      if (r_hold_full && w_vs_rise) begin
         w_push       = 1'b1;
         w_push_entry = {r_hold_sof, 1'b1, r_hold_data};
         w_hold_clear = 1'b1;
         w_trunc      = 1'b1;
      end else if (r_hold_full && w_hs_fall) begin
         w_push       = 1'b1;
         w_push_entry = {r_hold_sof, 1'b1, r_hold_data};
         w_hold_clear = 1'b1;
      end else if (w_pix_vld && w_accept && !w_vs_rise) begin
         w_hold_load  = 1'b1;
         if (r_hold_full) begin
            w_push       = 1'b1;
            w_push_entry = {r_hold_sof, 1'b0, r_hold_data};
         end
      end
   end

   assign w_pop       = m_axis_tready & ~w_fifo_empty;
   assign w_ovf       = w_push & w_fifo_full & ~w_pop;
   assign w_fifo_push = w_push & ~w_ovf;

   // Frame sequencing.
   always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= WAIT_VS;
      end else begin
         case (r_state)
            WAIT_VS: if (w_vs_rise) r_state <= SYNC;
            SYNC:    if (!w_vs_rise && w_hold_load) r_state <= ACTIVE;
            ACTIVE:  begin
               if (w_vs_rise)  r_state <= SYNC;
               else if (w_ovf) r_state <= DROP;
            end
            DROP:    if (w_vs_rise) r_state <= SYNC;
            default: r_state <= WAIT_VS;
         endcase
      end
   end

   // One-pixel hold register; the first pixel loaded in SYNC carries SOF.
   always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_hold_full <= 1'b0;
         r_hold_sof  <= 1'b0;
         r_hold_data <= '0;
      end else if (w_hold_load && !w_ovf) begin
         r_hold_full <= 1'b1;
         r_hold_sof  <= (r_state == SYNC);
         r_hold_data <= rgb565_i;
      end else if (w_hold_clear || w_ovf) begin
         r_hold_full <= 1'b0;
      end
   end

   // Geometry measurement. A line only counts if it carried pixels inside a
   // frame, so href edges during blanking or after a truncation are ignored.
   assign w_count_en  = (r_state != WAIT_VS);
   assign w_line_end  = w_hs_fall & r_line_open;
   assign w_width_bad = w_line_end & (r_pix_cnt != CNT_W'(H_ACTIVE));
   assign w_line_next = w_line_end ? sat_inc(r_line_cnt) : r_line_cnt;
   assign w_frame_bad = r_err_acc | w_width_bad | w_trunc | w_ovf |
                        (r_state == DROP) | (w_line_next != CNT_W'(V_ACTIVE));

   // Counters, geometry outputs and the per-frame error pulse.
   always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pix_cnt    <= '0;
         r_line_cnt   <= '0;
         r_line_open  <= 1'b0;
         r_err_acc    <= 1'b0;
         r_pix_cnt_o  <= '0;
         r_line_cnt_o <= '0;
         r_ovf        <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_ovf) r_ovf <= 1'b1;
         if (w_line_end) r_pix_cnt_o <= r_pix_cnt;
         if (w_vs_rise) begin
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_line_open  <= 1'b0;
            r_err_acc    <= 1'b0;
            r_line_cnt_o <= w_line_next;
            r_frame_err  <= w_count_en & w_frame_bad;
         end else if (w_line_end) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= w_line_next;
            r_line_open <= 1'b0;
            if (w_width_bad) r_err_acc <= 1'b1;
         end else if (w_pix_vld && w_count_en) begin
            r_pix_cnt   <= sat_inc(r_pix_cnt);
            r_line_open <= 1'b1;
         end
      end
   end

   sync_fifo_v1 #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (cmos_pclk_i),
      .i_rst_n (rst_n_i),
      .i_push  (w_fifo_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Head fields are forced to zero when nothing is queued.
   assign m_axis_tvalid = ~w_fifo_empty;
   assign m_axis_tuser  = w_fifo_empty ? 1'b0 : w_head[ENTRY_W-1];
   assign m_axis_tlast  = w_fifo_empty ? 1'b0 : w_head[ENTRY_W-2];
   assign m_axis_tdata  = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
   assign pix_cnt_o     = r_pix_cnt_o;
   assign line_cnt_o    = r_line_cnt_o;
   assign ovf_o         = r_ovf;
   assign frame_err_o   = r_frame_err;

endmodule

// File: tb/tb_cmos_rgb565_axis_bridge.sv
// Directed bench for the CMOS to AXI4-Stream bridge with a beat scoreboard.
module tb_cmos_rgb565_axis_bridge;

   localparam int H     = 8;
   localparam int V     = 4;
   localparam int DEPTH = 16;
   localparam int GAP   = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vs;
   logic        hs;
   logic        ce;
   logic [15:0] rgb;
   logic        tready;
   logic [15:0] tdata;
   logic        tvalid;
   logic        tuser;
   logic        tlast;
   logic [11:0] pix_cnt;
   logic [11:0] line_cnt;
   logic        ovf;
   logic        ferr;

   logic [17:0] exp_q [$];
   logic [17:0] mon_e;
   int checks = 0;
   int errors = 0;
   int beats = 0;
   int err_pulses = 0;
   int rdy_mode = 0;
   int b0;
   int e0;

   always #5 clk = ~clk;

   cmos_rgb565_axis_bridge #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .cmos_pclk_i   (clk),
      .rst_n_i       (rst_n),
      .vs_i          (vs),
      .hs_i          (hs),
      .rgb565_i      (rgb),
      .vid_clk_ce_i  (ce),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tuser  (tuser),
      .m_axis_tlast  (tlast),
      .pix_cnt_o     (pix_cnt),
      .line_cnt_o    (line_cnt),
      .ovf_o         (ovf),
      .frame_err_o   (ferr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (ferr === 1'b1) err_pulses++;
      if (tvalid === 1'b1 && tready === 1'b1) begin
         beats++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL beat_unexpected: observed %0h expected none", {tuser, tlast, tdata});
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("beat", {14'b0, tuser, tlast, tdata}, {14'b0, mon_e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       tready = 1'b1;
         1:       tready = ~tready;
         default: tready = 1'b0;
      endcase
   endtask

   task automatic idle(input int n);
      ce = 1'b0;
      repeat (n) tick();
   endtask

   task automatic vs_pulse();
      ce = 1'b0;
      hs = 1'b0;
      vs = 1'b1;
      idle(4);
      vs = 1'b0;
      idle(4);
   endtask

   task automatic send_px(input int n, input bit sof, input bit exp_en, input bit eol);
      hs = 1'b1;
      for (int i = 0; i < n; i++) begin
         ce  = 1'b1;
         rgb = 16'($urandom);
         if (exp_en) exp_q.push_back({sof && (i == 0), eol && (i == n - 1), rgb});
         tick();
      end
      ce = 1'b0;
   endtask

   task automatic send_line(input int n, input bit sof, input bit exp_en);
      send_px(n, sof, exp_en, 1'b1);
      hs = 1'b0;
      idle(GAP);
   endtask

   task automatic send_frame(input bit exp_en);
      for (int l = 0; l < V; l++) send_line(H, l == 0, exp_en);
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || tvalid === 1'b1) && k < 500) begin
         tick();
         k++;
      end
      chk({tag, "_drain_timeout"}, (k < 500), 1);
      chk({tag, "_left"}, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; vs = 1'b0; hs = 1'b0; ce = 1'b0; rgb = '0; tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tuser", tuser, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_pix", pix_cnt, 0);
      chk("rst_line", line_cnt, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ferr", ferr, 0);
      rst_n = 1'b1;
      idle(3);

      // 1: two clean frames, tready held high; first vsync leaves WAIT_VS silently
      e0 = err_pulses;
      vs_pulse();
      for (int f = 0; f < 2; f++) begin
         b0 = beats;
         send_frame(1'b1);
         vs_pulse();
         wait_drain("t1");
         chk("t1_beats", beats - b0, 32);
         chk("t1_line_cnt", line_cnt, V);
         chk("t1_pix_cnt", pix_cnt, H);
      end
      chk("t1_ferr", err_pulses - e0, 0);

      // 2: tready toggling every cycle
      rdy_mode = 1;
      e0 = err_pulses;
      b0 = beats;
      send_frame(1'b1);
      vs_pulse();
      wait_drain("t2");
      chk("t2_beats", beats - b0, 32);
      chk("t2_ovf", ovf, 0);
      chk("t2_ferr", err_pulses - e0, 0);
      rdy_mode = 0;
      tick();

      // 3: no ready for a whole frame, only the first 16 pixels survive
      rdy_mode = 2;
      tready = 1'b0;
      e0 = err_pulses;
      b0 = beats;
      for (int l = 0; l < V; l++) send_line(H, l == 0, l < 2);
      vs_pulse();
      chk("t3_ovf", ovf, 1);
      chk("t3_tvalid", tvalid, 1);
      chk("t3_ferr", err_pulses - e0, 1);
      rdy_mode = 0;
      wait_drain("t3a");
      chk("t3_beats_kept", beats - b0, DEPTH);
      e0 = err_pulses;
      b0 = beats;
      send_frame(1'b1);
      vs_pulse();
      wait_drain("t3b");
      chk("t3_next_beats", beats - b0, 32);
      chk("t3_next_ferr", err_pulses - e0, 0);

      // 4: second line one pixel short
      e0 = err_pulses;
      send_line(H, 1'b1, 1'b1);
      send_line(H - 1, 1'b0, 1'b1);
      chk("t4_pix_short", pix_cnt, H - 1);
      send_line(H, 1'b0, 1'b1);
      send_line(H, 1'b0, 1'b1);
      chk("t4_pix_back", pix_cnt, H);
      vs_pulse();
      wait_drain("t4");
      chk("t4_ferr", err_pulses - e0, 1);
      chk("t4_line_cnt", line_cnt, V);

      // 5: vsync rises mid-line after 3 pixels
      e0 = err_pulses;
      send_px(3, 1'b1, 1'b1, 1'b1);
      vs = 1'b1;
      idle(3);
      hs = 1'b0;
      idle(3);
      vs = 1'b0;
      idle(4);
      chk("t5_ferr", err_pulses - e0, 1);
      chk("t5_line_cnt", line_cnt, 0);
      wait_drain("t5a");
      b0 = beats;
      send_frame(1'b1);
      vs_pulse();
      wait_drain("t5b");
      chk("t5_next_beats", beats - b0, 32);
      chk("t5_next_ferr", err_pulses - e0, 1);
      chk("t5_next_line_cnt", line_cnt, V);

      // 6: asynchronous reset mid-line with entries queued
      rdy_mode = 2;
      tready = 1'b0;
      send_px(6, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("t6_pre_tvalid", tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_tvalid", tvalid, 0);
      chk("t6_tdata", tdata, 0);
      chk("t6_tuser", tuser, 0);
      chk("t6_tlast", tlast, 0);
      chk("t6_ovf", ovf, 0);
      chk("t6_pix", pix_cnt, 0);
      chk("t6_line", line_cnt, 0);
      chk("t6_ferr", ferr, 0);
      hs = 1'b0;
      exp_q.delete();
      rdy_mode = 0;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      b0 = beats;
      e0 = err_pulses;
      send_line(H, 1'b0, 1'b0);
      send_line(H, 1'b0, 1'b0);
      chk("t6_ignored_beats", beats - b0, 0);
      chk("t6_ignored_pix", pix_cnt, 0);
      vs_pulse();
      send_frame(1'b1);
      vs_pulse();
      wait_drain("t6");
      chk("t6_frame_beats", beats - b0, 32);
      chk("t6_ferr_after", err_pulses - e0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
